// File: rtl/move_scheduler.sv
// move_scheduler: serialises one maze-RAM wall lookup per enabled entity per
// game step, then reports per-entity move permission and a pac-man/ghost
// collision flag in a single COMMIT cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   tick         game-step pulse; starts a round when the FSM is idle
//   en           per-entity enable (bit 0 = pac-man, others = ghosts)
//   cand_blocks  candidate next block per entity, entity i in [i*AW +: AW]
//   mem_rd_en    maze-RAM read strobe
//   mem_addr     maze-RAM read address
//   mem_rdata    maze-RAM data (1 = wall), valid the cycle after mem_rd_en
//   busy         high whenever a round is in progress
//   can_move     per-entity move permission, pulsed with done
//   done         one-cycle round-complete pulse
//   hit          pac-man/ghost collision flag, valid with done
//   overrun      sticky: a tick arrived while busy
module move_scheduler #(
  parameter int N_ENT = 4,
  parameter int AW    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [N_ENT-1:0]    en,
  input  logic [N_ENT*AW-1:0] cand_blocks,
  output logic                mem_rd_en,
  output logic [AW-1:0]       mem_addr,
  input  logic                mem_rdata,
  output logic                busy,
  output logic [N_ENT-1:0]    can_move,
  output logic                done,
  output logic                hit,
  output logic                overrun
);

  localparam int IW = (N_ENT > 1) ? $clog2(N_ENT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_COMMIT} state_e;
  typedef logic [31:0] u32_t;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_ENT-1:0]    en_q, en_d;
  logic [N_ENT*AW-1:0] cand_q, cand_d;
  logic [N_ENT-1:0]    res_q, res_d;
  logic                ovr_q, ovr_d;

  logic                first_found, next_found, hit_c;
  logic [IW-1:0]       first_idx, next_idx;
  logic [AW-1:0]       cur_cand;

  // Priority scans: iterating downwards leaves the lowest qualifying index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = N_ENT; i > 0; i--) begin
      if (en[i-1]) begin
        first_found = 1'b1;
        first_idx   = IW'(i-1);
      end
      if (en_q[i-1] && (u32_t'(idx_q) < (i-1))) begin
        next_found = 1'b1;
        next_idx   = IW'(i-1);
      end
    end
  end

  always_comb begin
    cur_cand = '0;
    for (int unsigned i = 0; i < N_ENT; i++) begin
      if (u32_t'(idx_q) == i) cur_cand = cand_q[i*AW +: AW];
    end
  end

  // Collision depends only on the snapshot, never on wall results.
  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 1; i < N_ENT; i++) begin
      if (en_q[i] && (cand_q[i*AW +: AW] == cand_q[0 +: AW])) hit_c = 1'b1;
    end
    hit_c = hit_c & en_q[0];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = en_q;
    cand_d    = cand_q;
    res_d     = res_q;
    ovr_d     = ovr_q | (tick && (state_q != S_IDLE));
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    can_move  = '0;
    done      = 1'b0;
    hit       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          en_d    = en;
          cand_d  = cand_blocks;
          res_d   = '0;
          idx_d   = first_idx;
          state_d = first_found ? S_READ : S_COMMIT;
        end
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = cur_cand;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        for (int unsigned i = 0; i < N_ENT; i++) begin
          if (u32_t'(idx_q) == i) res_d[i] = ~mem_rdata;
        end
        if (next_found) begin
          idx_d   = next_idx;
          state_d = S_READ;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        can_move = res_q;
        done     = 1'b1;
        hit      = hit_c;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      cand_q  <= '0;
      res_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      cand_q  <= cand_d;
      res_q   <= res_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign overrun = ovr_q;

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter N_ENT, default 4, number of moving entities; entity 0 is pac-man, entities 1..N_ENT-1 are ghosts.
REQ-002 Parameter AW, default 10, maze block index width (32x32 grid, index = row*32 + col).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-005 tick  in  1  game-step pulse; starts one scheduling round when accepted.
REQ-006 en  in  N_ENT  per-entity enable; bit i = 1 means entity i takes part in the round.
REQ-007 cand_blocks  in  N_ENT*AW  candidate next block per entity, entity i in bits [i*AW +: AW].
REQ-008 mem_rd_en  out  1  maze-RAM read strobe.
REQ-009 mem_addr  out  AW  maze-RAM read address.
REQ-010 mem_rdata  in  1  maze-RAM data (1 = wall), valid exactly one cycle after the mem_rd_en cycle.
REQ-011 busy  out  1  high whenever the FSM is not IDLE.
REQ-012 can_move  out  N_ENT  per-entity move permission, one-cycle pulse vector.
REQ-013 done  out  1  one-cycle round-complete pulse.
REQ-014 hit  out  1  pac-man/ghost collision flag, valid with done.
REQ-015 overrun  out  1  sticky flag: a tick arrived while busy.

Function
REQ-016 The block SHALL be the sole master of the maze-RAM read port and SHALL serialise one wall lookup per enabled entity per round.
REQ-017 FSM states SHALL be IDLE, READ, WAIT and COMMIT.
REQ-018 In IDLE with tick=1 at a rising edge, the block SHALL snapshot en and cand_blocks, set idx to the lowest enabled entity, and enter READ (or COMMIT if the snapshot en is all zero).
REQ-019 The block SHALL use only the snapshot values for the rest of the round; changes on en and cand_blocks mid-round SHALL have no effect.
REQ-020 In READ: mem_rd_en=1 and mem_addr=snapshot candidate[idx]; the next state SHALL be WAIT.
REQ-021 In WAIT the block SHALL capture result[idx] = ~mem_rdata, then go to READ with idx = next higher enabled entity, or to COMMIT if none remain.
REQ-022 Entities disabled in the snapshot SHALL be skipped, with no RAM read and result = 0.
REQ-023 Outside READ: mem_rd_en=0 and mem_addr=0.
REQ-024 In COMMIT (exactly one cycle): can_move = result vector; done=1; hit=1 if any enabled ghost's snapshot candidate equals pac-man's snapshot candidate and pac-man is enabled, else 0; next state IDLE.
REQ-025 can_move, done and hit SHALL be 0 in every state other than COMMIT.
REQ-026 Latency: with k enabled entities, COMMIT SHALL occupy the cycle beginning 2k+1 edges after the tick-sampling edge (k=4 gives 9; k=0 gives 1).
REQ-027 hit SHALL be reported regardless of wall results.
REQ-028 A tick sampled in READ, WAIT or COMMIT SHALL be ignored and SHALL set overrun=1; overrun SHALL clear only on reset.
REQ-029 A tick held high across consecutive edges SHALL start a new round on each edge at which the FSM is in IDLE; the cycle after COMMIT is IDLE.
REQ-030 Candidate indices SHALL be used as-is (modulo 2^AW); there is no bounds check.

Reset
REQ-031 While reset=0: state=IDLE, idx=0, results and snapshot cleared, and mem_rd_en, mem_addr, busy, can_move, done, hit and overrun all 0.
REQ-032 Reset asserted mid-round SHALL abort the round with no done pulse; the first tick after release SHALL start a fresh round.

Verification
REQ-033 All enabled; cands {e3..e0} = {100,70,34,33}; RAM walls only at 70; tick -> reads at 33,34,70,100 in order, done on the 9th edge after the tick-sampling edge, can_move=4'b1011, hit=0.
REQ-034 en=4'b0000; tick -> done on the 1st edge after the tick-sampling edge, can_move=0, no mem_rd_en.
REQ-035 en=4'b0101; cands e0=e2=200; no walls -> exactly 2 reads (200,200), can_move=4'b0101, hit=1, done at edge 5.
REQ-036 A second tick during WAIT of entity 1 -> ignored, round completes unchanged, overrun=1 until reset.
REQ-037 reset pulled low during READ of entity 2 -> outputs 0 asynchronously, no done; the next tick after release gives a normal full round.
REQ-038 cand_blocks changed on the cycle after the tick -> addresses and hit still reflect the snapshot values.
